// File: rtl/aes_mix_pkg.sv
// Shared definitions for the MixColumns/InvMixColumns AXI4-Lite peripheral:
// register word indices, AXI response codes, engine states and GF(2^8) helpers.
package aes_mix_pkg;

  // Word indices (byte address bits [5:2])
  localparam logic [1:0] BANK_DATA_IN  = 2'b00;
  localparam logic [1:0] BANK_DATA_OUT = 2'b10;
  localparam logic [3:0] WIDX_CTRL     = 4'h4;
  localparam logic [3:0] WIDX_STATUS   = 4'h5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Circulant coefficient rows, nibble k multiplies byte (row + k) mod 4
  localparam logic [15:0] FWD_COEF = 16'h1132;
  localparam logic [15:0] INV_COEF = 16'h9DBE;

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (k)
      4'h1:    return b;
      4'h2:    return x2;
      4'h3:    return x2 ^ b;
      4'h9:    return x8 ^ b;
      4'hB:    return x8 ^ x2 ^ b;
      4'hD:    return x8 ^ x4 ^ b;
      4'hE:    return x8 ^ x4 ^ x2;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_mix_imix_axil_slave_mix_column_unit.sv
// Combinational single-column MixColumns (inv=0) or InvMixColumns (inv=1).
// Byte 0 of the column is row 0.
module mix_column_unit
  import aes_mix_pkg::*;
(
  input  logic [31:0] col_in,
  input  logic        inv,
  output logic [31:0] col_out
);

  logic [15:0] coef;

  assign coef = inv ? INV_COEF : FWD_COEF;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      assign col_out[8*gi +: 8] = gf_mul(col_in[8*gi +: 8],           coef[3:0])
                                ^ gf_mul(col_in[8*((gi+1)%4) +: 8], coef[7:4])
                                ^ gf_mul(col_in[8*((gi+2)%4) +: 8], coef[11:8])
                                ^ gf_mul(col_in[8*((gi+3)%4) +: 8], coef[15:12]);
    end
  endgenerate

endmodule

// File: rtl/aes_mix_imix_axil_slave.sv
// AXI4-Lite register front end plus a one-column-per-cycle engine that
// transforms a snapshot of DATA_IN into DATA_OUT.
module aes_mix_imix_axil_slave
  import aes_mix_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_reset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic                            irq_done
);

  logic        awready_reg, bvalid_reg, arready_reg, rvalid_reg, irq_reg;
  logic [1:0]  bresp_reg, rresp_reg;
  logic [31:0] rdata_reg;
  logic [31:0] data_in  [4];
  logic [31:0] snap     [4];
  logic [31:0] data_out [4];
  logic        inv_reg, snap_inv_reg, done_reg, done_next;
  state_t      state_reg, state_next;
  logic [1:0]  col_reg, col_next;
  logic        col_we, snap_load, wr_fire, rd_fire, start_req;
  logic [3:0]  wr_idx, rd_idx;
  logic [1:0]  wr_resp, rd_resp;
  logic [31:0] rd_data, mix_out;
  logic        unused_ok;

  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign wr_idx    = s00_axi_awaddr[5:2];
  assign rd_idx    = s00_axi_araddr[5:2];
  assign wr_fire   = awready_reg && s00_axi_awvalid && s00_axi_wvalid;
  assign rd_fire   = arready_reg && s00_axi_arvalid;
  assign start_req = wr_fire && (wr_idx == WIDX_CTRL) && s00_axi_wstrb[0] && s00_axi_wdata[0];
  assign wr_resp   = (wr_idx[3:2] == BANK_DATA_IN || wr_idx == WIDX_CTRL ||
                      wr_idx == WIDX_STATUS || wr_idx[3:2] == BANK_DATA_OUT) ? RESP_OKAY : RESP_SLVERR;

  always_comb begin
    state_next = state_reg;
    done_next  = done_reg;
    col_next   = col_reg;
    col_we     = 1'b0;
    snap_load  = 1'b0;
    case (state_reg)
      IDLE: if (start_req) begin
        state_next = RUN;
        done_next  = 1'b0;
        col_next   = 2'd0;
        snap_load  = 1'b1;
      end
      RUN: begin
        col_we   = 1'b1;
        col_next = col_reg + 2'd1;
        if (col_reg == 2'd3) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // STATUS reports the post-edge engine state so a read accepted on the
  // completing edge already sees DONE.
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    if (rd_idx[3:2] == BANK_DATA_IN)       rd_data = data_in[rd_idx[1:0]];
    else if (rd_idx == WIDX_CTRL)          rd_data = {30'd0, inv_reg, 1'b0};
    else if (rd_idx == WIDX_STATUS)        rd_data = {30'd0, done_next, state_next == RUN};
    else if (rd_idx[3:2] == BANK_DATA_OUT) rd_data = data_out[rd_idx[1:0]];
    else                                   rd_resp = RESP_SLVERR;
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_reset) begin
      awready_reg <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rresp_reg   <= RESP_OKAY;
      rdata_reg   <= '0;
    end else begin
      awready_reg <= !awready_reg && s00_axi_awvalid && s00_axi_wvalid && !bvalid_reg;
      if (wr_fire) begin
        bvalid_reg <= 1'b1;
        bresp_reg  <= wr_resp;
      end else if (s00_axi_bready) begin
        bvalid_reg <= 1'b0;
      end
      arready_reg <= !arready_reg && s00_axi_arvalid && !rvalid_reg;
      if (rd_fire) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_data;
        rresp_reg  <= rd_resp;
      end else if (s00_axi_rready) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_reset) begin
      state_reg    <= IDLE;
      col_reg      <= 2'd0;
      done_reg     <= 1'b0;
      irq_reg      <= 1'b0;
      inv_reg      <= 1'b0;
      snap_inv_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      done_reg  <= done_next;
      irq_reg   <= (state_reg == RUN) && (state_next == IDLE);
      if (wr_fire && wr_idx == WIDX_CTRL && s00_axi_wstrb[0]) inv_reg <= s00_axi_wdata[1];
      // Take INV from the same CTRL write that carries START
      if (snap_load) snap_inv_reg <= s00_axi_wdata[1];
    end
  end

  mix_column_unit u_mix (
    .col_in  (snap[col_reg]),
    .inv     (snap_inv_reg),
    .col_out (mix_out)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_word
      logic [31:0] din_reg, snap_reg, dout_reg;
      always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_reset) begin
          din_reg  <= '0;
          snap_reg <= '0;
          dout_reg <= '0;
        end else begin
          if (wr_fire && wr_idx == 4'(gi)) begin
            for (int b = 0; b < 4; b++)
              if (s00_axi_wstrb[b]) din_reg[8*b +: 8] <= s00_axi_wdata[8*b +: 8];
          end
          if (snap_load) snap_reg <= din_reg;
          if (col_we && col_reg == 2'(gi)) dout_reg <= mix_out;
        end
      end
      assign data_in[gi]  = din_reg;
      assign snap[gi]     = snap_reg;
      assign data_out[gi] = dout_reg;
    end
  endgenerate

  assign s00_axi_awready = awready_reg;
  assign s00_axi_wready  = awready_reg;
  assign s00_axi_bvalid  = bvalid_reg;
  assign s00_axi_bresp   = bresp_reg;
  assign s00_axi_arready = arready_reg;
  assign s00_axi_rvalid  = rvalid_reg;
  assign s00_axi_rresp   = rresp_reg;
  assign s00_axi_rdata   = rdata_reg;
  assign irq_done        = irq_reg;

endmodule

// File: tb/tb_aes_mix_imix_axil_slave.sv
// Directed + randomized bench for the MixColumns AXI4-Lite peripheral,
// checked against a matrix-product GF(2^8) reference model.
module tb_aes_mix_imix_axil_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid, irq_done;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int vectors = 0, miscompares = 0;
  int cyc = 0, irq_count = 0, irq_cyc = 0, wr_cyc = 0, start_cyc = 0, irq0 = 0;
  logic [31:0] shadow [4];
  logic [31:0] rd_v;
  logic [1:0]  rs;
  bit          inv_sel;

  localparam logic [31:0] VEC_IN  [4] = '{32'h455313DB, 32'h5C220AF2, 32'h01010101, 32'hD5D4D4D4};
  localparam logic [31:0] VEC_OUT [4] = '{32'hBCA14D8E, 32'h9D58DC9F, 32'h01010101, 32'hD6D7D5D5};

  int fwd_m [4][4] = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
  int inv_m [4][4] = '{'{14, 11, 13, 9}, '{9, 14, 11, 13}, '{13, 9, 14, 11}, '{11, 13, 9, 14}};

  aes_mix_imix_axil_slave dut (
    .s00_axi_aclk    (clk),
    .s00_axi_reset   (rst),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .irq_done        (irq_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (irq_done === 1'b1) begin irq_count++; irq_cyc = cyc; end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Shift-and-add GF(2^8) multiply, polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input int k);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [31:0] model_mix(input logic [31:0] col, input bit inv);
    logic [31:0] r;
    r = '0;
    for (int row = 0; row < 4; row++)
      for (int c = 0; c < 4; c++)
        r[8*row +: 8] = r[8*row +: 8] ^ gmul(col[8*c +: 8], inv ? inv_m[row][c] : fwd_m[row][c]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int hold, output logic [1:0] resp);
    int n;
    n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    while (awready !== 1'b1 && n < 16) begin @(posedge clk); #1; n++; end
    check("aw_handshake", {wready, awready}, 2'b11);
    @(posedge clk); #1;
    wr_cyc = cyc;
    awvalid = 1'b0; wvalid = 1'b0;
    check("aw_pulse_bvalid", {awready, bvalid}, 2'b01);
    resp = bresp;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("bvalid_hold", {bvalid, bresp}, {1'b1, resp});
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("bvalid_clear", bvalid, 1'b0);
    $display("wr addr=%02h data=%08h strb=%h resp=%0d", a, d, s, resp);
  endtask

  task automatic axi_read(input logic [5:0] a, input int hold,
                          output logic [31:0] data, output logic [1:0] resp);
    int n;
    n = 0;
    araddr = a; arvalid = 1'b1;
    @(posedge clk); #1;
    while (arready !== 1'b1 && n < 16) begin @(posedge clk); #1; n++; end
    check("ar_handshake", arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    check("ar_pulse_rvalid", {arready, rvalid}, 2'b01);
    data = rdata;
    resp = rresp;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("rvalid_hold", {rvalid, rresp, rdata}, {1'b1, resp, data});
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check("rvalid_clear", rvalid, 1'b0);
    $display("rd addr=%02h data=%08h resp=%0d", a, data, resp);
  endtask

  task automatic load_din();
    logic [1:0] r;
    for (int i = 0; i < 4; i++) begin
      axi_write(6'(4*i), shadow[i], 4'hF, 0, r);
      check("din_wr_resp", r, 2'b00);
    end
  endtask

  task automatic start(input bit inv);
    logic [1:0] r;
    axi_write(6'h10, {30'd0, inv, 1'b1}, 4'hF, 0, r);
    start_cyc = wr_cyc;
    check("ctrl_resp", r, 2'b00);
  endtask

  task automatic wait_done();
    logic [31:0] st;
    logic [1:0]  r;
    int n;
    n = 0;
    do begin axi_read(6'h14, 0, st, r); n++; end while (st[1] !== 1'b1 && n < 20);
    check("done_poll", st, 32'h2);
  endtask

  task automatic check_out(input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] d;
    logic [1:0]  r;
    logic [31:0] e [4];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      axi_read(6'h20 + 6'(4*i), 0, d, r);
      check("data_out", {r, d}, {2'b00, e[i]});
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {awready, wready, bvalid, bresp, arready, rvalid, rresp, irq_done}, 11'd0);
    check("reset_rdata", rdata, 32'd0);
    rst = 1'b0;

    // DATA_IN readback and DATA_OUT after reset
    shadow = '{32'd1, 32'd2, 32'd3, 32'd4};
    load_din();
    for (int i = 0; i < 4; i++) begin
      axi_read(6'(4*i), 0, rd_v, rs);
      check("din_readback", {rs, rd_v}, {2'b00, shadow[i]});
    end
    check_out(32'd0, 32'd0, 32'd0, 32'd0);

    // Forward known vector, with STATUS while busy and irq latency
    shadow = VEC_IN;
    load_din();
    irq0 = irq_count;
    start(1'b0);
    axi_read(6'h14, 0, rd_v, rs);
    check("status_busy", rd_v, 32'h1);
    wait_done();
    check("irq_once", irq_count - irq0, 1);
    check("irq_latency", irq_cyc - start_cyc, 4);
    check_out(VEC_OUT[0], VEC_OUT[1], VEC_OUT[2], VEC_OUT[3]);
    axi_read(6'h10, 0, rd_v, rs);
    check("ctrl_read", rd_v, 32'h0);

    // Inverse brings the original state back
    shadow = VEC_OUT;
    load_din();
    start(1'b1);
    axi_read(6'h14, 0, rd_v, rs);
    check("status_busy_done_clr", rd_v, 32'h1);
    wait_done();
    check_out(VEC_IN[0], VEC_IN[1], VEC_IN[2], VEC_IN[3]);
    axi_read(6'h10, 0, rd_v, rs);
    check("ctrl_inv_read", rd_v, 32'h2);

    // START while busy is ignored: one completion only
    shadow = VEC_IN;
    load_din();
    irq0 = irq_count;
    start(1'b0);
    start(1'b0);
    wait_done();
    repeat (10) @(posedge clk);
    #1;
    check("single_irq", irq_count - irq0, 1);
    check_out(VEC_OUT[0], VEC_OUT[1], VEC_OUT[2], VEC_OUT[3]);

    // DATA_IN overwrite while busy does not disturb the snapshot
    start(1'b0);
    axi_write(6'h00, 32'hFFFFFFFF, 4'hF, 0, rs);
    shadow[0] = 32'hFFFFFFFF;
    wait_done();
    check_out(VEC_OUT[0], VEC_OUT[1], VEC_OUT[2], VEC_OUT[3]);
    axi_read(6'h00, 0, rd_v, rs);
    check("din_busy_stored", rd_v, 32'hFFFFFFFF);

    // Error decode, RO writes, byte strobes
    axi_read(6'h30, 0, rd_v, rs);
    check("bad_read", {rs, rd_v}, {2'b10, 32'd0});
    axi_write(6'h38, 32'h12345678, 4'hF, 0, rs);
    check("bad_write_resp", rs, 2'b10);
    axi_write(6'h20, 32'h12345678, 4'hF, 0, rs);
    check("ro_write_resp", rs, 2'b00);
    check_out(VEC_OUT[0], VEC_OUT[1], VEC_OUT[2], VEC_OUT[3]);
    for (int i = 0; i < 4; i++) begin
      axi_read(6'(4*i), 0, rd_v, rs);
      check("din_unchanged", rd_v, shadow[i]);
    end
    axi_write(6'h00, 32'h11111111, 4'hF, 0, rs);
    axi_write(6'h00, 32'hAABBCCDD, 4'b0010, 0, rs);
    axi_read(6'h00, 0, rd_v, rs);
    check("wstrb_merge", rd_v, 32'h1111CC11);

    // Backpressure: responses held with stable payload
    axi_read(6'h00, 10, rd_v, rs);
    check("held_read_data", rd_v, 32'h1111CC11);
    axi_write(6'h3C, 32'h0, 4'hF, 10, rs);
    check("held_write_resp", rs, 2'b10);

    // Randomized vectors against the reference model
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 4; i++) shadow[i] = $urandom;
      inv_sel = 1'($urandom_range(0, 1));
      load_din();
      start(inv_sel);
      wait_done();
      check_out(model_mix(shadow[0], inv_sel), model_mix(shadow[1], inv_sel),
                model_mix(shadow[2], inv_sel), model_mix(shadow[3], inv_sel));
    end

    // Reset in the middle of a transform
    shadow = VEC_IN;
    load_din();
    start(1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    irq0 = irq_count;
    repeat (8) @(posedge clk);
    #1;
    check("reset_no_irq", irq_count - irq0, 0);
    axi_read(6'h14, 0, rd_v, rs);
    check("reset_status", rd_v, 32'h0);
    check_out(32'd0, 32'd0, 32'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
